// File: rtl/iq_capture_buffer_if.sv
// Bus bundle for iq_capture_buffer: sample stream, capture control, CSR read port and status.
// Optional force_trig line exists only when IQ_CAPTURE_FORCE_TRIG_EN is defined.
interface iq_capture_buffer_if #(
  parameter int ADDR_W = 10,
  parameter int DW     = 16
);
  // Stream handshake: in_valid qualifies in_x/in_y for exactly one clock; there is no
  // ready, the buffer accepts every strobe (back-to-back included) and never stalls the source.
  logic              in_valid;
  logic [DW-1:0]     in_x;
  logic [DW-1:0]     in_y;
  logic              arm;
  logic              abort;
  logic [DW-1:0]     trig_level;
  logic [ADDR_W-1:0] post_count;
  logic [ADDR_W-1:0] rd_addr;
  logic [2*DW-1:0]   rd_data;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] trig_addr;
  logic [ADDR_W-1:0] start_addr;
  logic [2:0]        state_dbg;
`ifdef IQ_CAPTURE_FORCE_TRIG_EN
  logic              force_trig;
`endif

  modport master (
`ifdef IQ_CAPTURE_FORCE_TRIG_EN
    output force_trig,
`endif
    output in_valid, in_x, in_y, arm, abort, trig_level, post_count, rd_addr,
    input  rd_data, busy, done, trig_addr, start_addr, state_dbg
  );

  modport slave (
`ifdef IQ_CAPTURE_FORCE_TRIG_EN
    input  force_trig,
`endif
    input  in_valid, in_x, in_y, arm, abort, trig_level, post_count, rd_addr,
    output rd_data, busy, done, trig_addr, start_addr, state_dbg
  );
endinterface

// File: rtl/iq_capture_buffer.sv
// Triggered I/Q snapshot ring: fills pre-trigger history, waits for a rising level crossing
// on X, stores post-trigger samples, then freezes for CSR readback. Macro: IQ_CAPTURE_FORCE_TRIG_EN.
module iq_capture_buffer #(
  parameter int ADDR_W = 10,
  parameter int DW     = 16
) (
  input logic                sys_clk,
  input logic                rst_n,
  iq_capture_buffer_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_POST = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]           state, state_next;
  logic [ADDR_W-1:0]    wr_ptr, cnt, pre_n, post_n;
  logic [ADDR_W-1:0]    cnt_inc, pre_calc;
  logic [ADDR_W-1:0]    trig_q, start_q;
  logic signed [DW-1:0] prev_x;
  logic                 busy_q, done_q;
  logic [2*DW-1:0]      rd_q;
  logic                 capturing, arm_ok, wr_en, level_hit, trig_hit, enter_done;
  logic [2*DW-1:0]      mem [DEPTH];

  assign capturing = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
  assign arm_ok    = bus.arm && !bus.abort && ((state == S_IDLE) || (state == S_DONE));
  assign wr_en     = bus.in_valid && capturing && !bus.abort;
  assign cnt_inc   = cnt + 1'b1;
  // post_count is only ADDR_W bits, so it is already within DEPTH-1 and the clamp is implicit
  assign pre_calc  = {ADDR_W{1'b1}} - bus.post_count;
  assign level_hit = (prev_x < $signed(bus.trig_level)) &&
                     ($signed(bus.in_x) >= $signed(bus.trig_level));

`ifdef IQ_CAPTURE_FORCE_TRIG_EN
  logic force_pend;
  assign trig_hit = wr_en && (state == S_WAIT) && (level_hit || force_pend);

  // Sticky request: only takes effect on strobes after the pulse cycle
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)                               force_pend <= 1'b0;
    else if (bus.abort || arm_ok || trig_hit) force_pend <= 1'b0;
    else if (bus.force_trig && state == S_WAIT) force_pend <= 1'b1;
  end
`else
  assign trig_hit = wr_en && (state == S_WAIT) && level_hit;
`endif

  always_comb begin
    state_next = state;
    if (bus.abort) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (arm_ok) state_next = (pre_calc != '0) ? S_PRE : S_WAIT;
        S_PRE:          if (wr_en && cnt_inc == pre_n) state_next = S_WAIT;
        S_WAIT:         if (trig_hit) state_next = (post_n != '0) ? S_POST : S_DONE;
        S_POST:         if (wr_en && cnt_inc == post_n) state_next = S_DONE;
        default:        state_next = S_IDLE;
      endcase
    end
  end

  assign enter_done = (state_next == S_DONE) && (state != S_DONE);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wr_ptr  <= '0;
      cnt     <= '0;
      pre_n   <= '0;
      post_n  <= '0;
      trig_q  <= '0;
      start_q <= '0;
      prev_x  <= '0;
    end else begin
      state  <= state_next;
      busy_q <= (state_next == S_PRE) || (state_next == S_WAIT) || (state_next == S_POST);
      done_q <= (state_next == S_DONE);
      if (bus.in_valid) prev_x <= $signed(bus.in_x);
      if (arm_ok) begin
        post_n <= bus.post_count;
        pre_n  <= pre_calc;
        wr_ptr <= '0;
        cnt    <= '0;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (state == S_PRE || state == S_POST) cnt <= cnt_inc;
        if (trig_hit) begin
          cnt    <= '0;
          trig_q <= wr_ptr;
        end
      end
      // The oldest sample sits just past the final write
      if (enter_done) start_q <= wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_ptr] <= {bus.in_y, bus.in_x};
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) rd_q <= '0;
    else        rd_q <= mem[bus.rd_addr];
  end

  assign bus.rd_data    = rd_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.trig_addr  = trig_q;
  assign bus.start_addr = start_q;
  assign bus.state_dbg  = state;
endmodule
